// File: rtl/apb_pkg.sv
// Shared constants for the APB master/arbiter slice.
// Holds the FSM state encoding and the default bus widths and timeout.
// No ports; imported by apb_master_arb.
package apb_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req & ~exclude, searching
// upward from the pointer with wrap; the pointer moves to winner+1 on update.
// Ports: req/exclude/update in; grant (one-hot), grant_idx, any_grant out.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] exclude,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] masked;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   cand;

  assign masked = req & ~exclude;

  // Walk NUM_REQ slots starting at the pointer; the first hit wins.
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any_grant && masked[cand]) begin
        any_grant = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ptr <= '0;
    end else if (update && any_grant) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master sharing one bus among NUM_REQ requesters (round-robin), with
// wait-state support and a stall timeout. Latency: req -> psel 1 cycle,
// penable 2, rsp_valid 3 (zero-wait slave); back-to-back every 2 cycles.
// Ports: req_* in (packed per requester), rsp_* out (one-cycle pulse),
// p* APB master side; all outputs registered.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]            state;
  logic [IDX_W-1:0]      cur_idx;
  logic [NUM_REQ-1:0]    cur_oh;
  logic [CNT_W-1:0]      wait_cnt;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [NUM_REQ-1:0]    arb_excl;
  logic                  arb_update;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;

  always_comb begin
    cur_oh          = '0;
    cur_oh[cur_idx] = 1'b1;
  end

  // The requester completing now still holds req_valid until it sees its
  // response, so it must be masked out of the arbitration it completes in.
  assign arb_excl   = (state == ST_ACCESS) ? cur_oh : '0;
  assign arb_update = (state == ST_IDLE) || ((state == ST_ACCESS) && pready);

  assign sel_addr  = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_write = |(req_write & arb_grant);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req_valid),
    .exclude   (arb_excl),
    .update    (arb_update),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      cur_idx   <= '0;
      wait_cnt  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            state    <= ST_SETUP;
            cur_idx  <= arb_idx;
            wait_cnt <= '0;
            psel     <= 1'b1;
            penable  <= 1'b0;
            pwrite   <= sel_write;
            paddr    <= sel_addr;
            pwdata   <= sel_wdata;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (pready) begin
            rsp_valid <= cur_oh;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            if (arb_any) begin
              // Chain straight into the next SETUP without dropping psel.
              state    <= ST_SETUP;
              cur_idx  <= arb_idx;
              wait_cnt <= '0;
              penable  <= 1'b0;
              pwrite   <= sel_write;
              paddr    <= sel_addr;
              pwdata   <= sel_wdata;
            end else begin
              state   <= ST_IDLE;
              psel    <= 1'b0;
              penable <= 1'b0;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th wait cycle: abandon the transfer.
            state     <= ST_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= cur_oh;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: table of single-requester transfers plus
// hand-written contention, reset-mid-transfer and timeout sequences.
// Slave model: 16-word memory with programmable wait states and error.
module tb_apb_master_arb;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 2;

  logic           pclk;
  logic           presetn;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic           pready;
  logic [DW-1:0]  prdata;
  logic           pslverr;

  apb_master_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(15)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [16];
  int            wait_req;
  int            acc_cnt;
  logic          slverr_force;

  assign pready  = (acc_cnt >= wait_req);
  assign prdata  = mem[paddr[5:2]];
  assign pslverr = slverr_force;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr[5:2]] <= pwdata;
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          rid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waitc;
    logic        serr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_pen;
  } vec_t;

  task automatic set_req(input int rid, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[rid]         = wr;
    req_addr[rid*AW +: AW] = a;
    req_wdata[rid*DW +: DW] = d;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int   cyc, first_ps, pen_cnt;
    logic addr_ok, done;
    @(posedge pclk); #1;
    wait_req     = v.waitc;
    slverr_force = v.serr;
    set_req(v.rid, v.wr, v.addr, v.wdata);
    req_valid[v.rid] = 1'b1;
    cyc = 0; first_ps = -1; pen_cnt = 0; addr_ok = 1'b1; done = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge pclk); #1;
      cyc++;
      if (psel && first_ps < 0) first_ps = cyc;
      if (penable) begin
        pen_cnt++;
        if (paddr !== v.addr || pwrite !== v.wr) addr_ok = 1'b0;
      end
      if (rsp_valid != '0) done = 1'b1;
    end
    req_valid[v.rid] = 1'b0;
    check($sformatf("v%0d_latency", n), cyc, v.exp_lat);
    check($sformatf("v%0d_rsp_valid", n), rsp_valid, 64'(1) << v.rid);
    check($sformatf("v%0d_rdata", n), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_err", n), rsp_err, v.exp_err);
    check($sformatf("v%0d_penable_cycles", n), pen_cnt, v.exp_pen);
    check($sformatf("v%0d_psel_cycle", n), first_ps, 1);
    check($sformatf("v%0d_addr_stable", n), addr_ok, 1);
    check($sformatf("v%0d_psel_after", n), {psel, penable}, 0);
    slverr_force = 1'b0;
    wait_req     = 0;
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[4];
    int rcyc[4];
    int rem[2];
    int ps_hist[64];
    int n, cyc, idx, first_ps;
    logic ps_ok;

    vecs[0] = '{0, 1'b1, 32'h4,  32'hA5A5_0001, 0,   1'b0, 32'h0,         1'b0, 3,  1};
    vecs[1] = '{0, 1'b0, 32'h4,  32'h0,         0,   1'b0, 32'hA5A5_0001, 1'b0, 3,  1};
    vecs[2] = '{1, 1'b1, 32'h8,  32'h1234_5678, 0,   1'b0, 32'h0,         1'b0, 3,  1};
    vecs[3] = '{1, 1'b0, 32'h8,  32'h0,         0,   1'b0, 32'h1234_5678, 1'b0, 3,  1};
    vecs[4] = '{0, 1'b1, 32'hC,  32'hDEAD_BEEF, 3,   1'b0, 32'h0,         1'b0, 6,  4};
    vecs[5] = '{1, 1'b0, 32'hC,  32'h0,         3,   1'b0, 32'hDEAD_BEEF, 1'b0, 6,  4};
    vecs[6] = '{0, 1'b0, 32'h4,  32'h0,         0,   1'b1, 32'hA5A5_0001, 1'b1, 3,  1};
    vecs[7] = '{1, 1'b1, 32'h10, 32'h55,        0,   1'b1, 32'h0,         1'b1, 3,  1};
    vecs[8] = '{0, 1'b0, 32'h4,  32'h0,         255, 1'b0, 32'h0,         1'b1, 17, 15};
    vecs[9] = '{1, 1'b0, 32'h4,  32'h0,         0,   1'b0, 32'hA5A5_0001, 1'b0, 3,  1};

    foreach (mem[i]) mem[i] = '0;
    presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    wait_req = 0; slverr_force = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_bus", {psel, penable, pwrite, paddr, pwdata}, 0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    #2 presetn = 1'b1;

    // ---- contention: both requesters, two transfers each ----
    @(posedge pclk); #1;
    set_req(0, 1'b1, 32'h20, 32'h111);
    set_req(1, 1'b1, 32'h24, 32'h222);
    req_valid = 2'b11;
    rem[0] = 2; rem[1] = 2;
    foreach (order[i]) begin order[i] = -1; rcyc[i] = 0; end
    foreach (ps_hist[i]) ps_hist[i] = 0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
      ps_hist[cyc] = int'(psel);
      if (rsp_valid != '0) begin
        idx = rsp_valid[1] ? 1 : 0;
        order[n] = idx; rcyc[n] = cyc; n++;
        rem[idx]--;
        if (rem[idx] == 0) req_valid[idx] = 1'b0;
      end
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], i % 2);
    check("rr_first_rsp_cycle", rcyc[0], 3);
    for (int i = 0; i < 3; i++) check($sformatf("rr_gap%0d", i), rcyc[i+1] - rcyc[i], 2);
    first_ps = 1; ps_ok = 1'b1;
    for (int c = first_ps; c < rcyc[3] && c < 64; c++) if (ps_hist[c] != 1) ps_ok = 1'b0;
    check("rr_psel_continuous", ps_ok, (rcyc[3] > 1) ? 1'b1 : 1'b0);
    check("rr_mem0", mem[8], 32'h111);
    check("rr_mem1", mem[9], 32'h222);

    // ---- table-driven single transfers ----
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // ---- reset asserted mid-ACCESS ----
    @(posedge pclk); #1;
    wait_req = 255;
    set_req(1, 1'b0, 32'h8, 32'h0);
    req_valid = 2'b10;
    cyc = 0;
    while (!penable && cyc < 20) begin @(posedge pclk); #1; cyc++; end
    check("rst_reached_access", penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    check("rst_bus_drop", {psel, penable}, 0);
    check("rst_no_rsp", rsp_valid, 0);
    wait_req = 0;
    set_req(0, 1'b0, 32'h4, 32'h0);
    req_valid = 2'b11;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_hold_no_rsp", {rsp_valid, psel}, 0);
    #2 presetn = 1'b1;
    cyc = 0;
    do begin @(posedge pclk); #1; cyc++; end while (!psel && cyc < 10);
    check("rst_first_grant_addr", paddr, 32'h4);
    req_valid[1] = 1'b0;
    cyc = 0;
    do begin @(posedge pclk); #1; cyc++; end while (rsp_valid == '0 && cyc < 10);
    req_valid = '0;
    check("rst_first_rsp", rsp_valid, 2'b01);
    check("rst_first_rdata", rsp_rdata, 32'hA5A5_0001);

    repeat (3) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
